sad_disparity_ctrl: RTL

Sequences the combinational SAD unit across a disparity search range for one left-image window. It issues disparity indices to the right-window fetch logic and accumulates the returned SAD costs. It tracks the minimum cost (winner-take-all) and returns the best disparity and its cost over a valid/ready result handshake. It sits between the pixel-window line buffers and the disparity-map writer.

---
 rtl/sad_pkg.sv | 33 +++
 rtl/sad_wta_min.sv | 30 +++
 rtl/sad_disparity_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared widths, state encoding and request clamping for the SAD
// disparity controller. Optional macro SAD_REJECT_EN adds REJECT_THRESH.
package sad_pkg;

    localparam int WIN       = 15;
    localparam int DATA_SIZE = 8;
    localparam int WIN_SIZE  = WIN * WIN;
    localparam int SAD_SIZE  = $clog2(WIN_SIZE * ((1 << DATA_SIZE) - 1) + 1);
    localparam int MAX_DISP  = 64;
    localparam int DISP_W    = $clog2(MAX_DISP + 1);

`ifdef SAD_REJECT_EN
    localparam logic [SAD_SIZE:0] REJECT_THRESH = (SAD_SIZE+1)'(4096);
`endif

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sad_state_t;

    // Zero requests still search one disparity; larger requests saturate.
    function automatic logic [DISP_W-1:0] clamp_ndisp(input logic [DISP_W-1:0] req);
        if (req == '0)
            return DISP_W'(1);
        else if (req > DISP_W'(MAX_DISP))
            return DISP_W'(MAX_DISP);
        else
            return req;
    endfunction

endpackage

// File: rtl/sad_wta_min.sv
// Winner-take-all running minimum: strict-less update keeps the earliest
// index on ties; clear restarts the search at all-ones cost.
module sad_wta_min
    import sad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [SAD_SIZE:0] cost,
    input  logic [DISP_W-1:0] index,
    output logic [SAD_SIZE:0] best_sad,
    output logic [DISP_W-1:0] best_disp
);

    // Track the lowest cost seen since the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad  <= '1;
            best_disp <= '0;
        end else if (clear) begin
            best_sad  <= '1;
            best_disp <= '0;
        end else if (valid && (cost < best_sad)) begin
            best_sad  <= cost;
            best_disp <= index;
        end
    end

endmodule

// File: rtl/sad_disparity_ctrl.sv
// Sequences disparity indices toward window fetch, collects in-order SAD
// returns, and reports the minimum-cost disparity over a result handshake.
// Optional macro SAD_REJECT_EN: res_reject flags costs above REJECT_THRESH.
module sad_disparity_ctrl
    import sad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DISP_W-1:0] req_ndisp,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [DISP_W-1:0] disp_idx,
    input  logic              sad_valid,
    input  logic [SAD_SIZE:0] sad_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DISP_W-1:0] res_disp,
    output logic [SAD_SIZE:0] res_sad,
    output logic              res_reject
);

    sad_state_t        state, state_nxt;
    logic [DISP_W-1:0] n_disp;
    logic [DISP_W-1:0] issue_cnt;
    logic [DISP_W-1:0] ret_cnt;
    logic [SAD_SIZE:0] best_sad;
    logic [DISP_W-1:0] best_disp;
    logic              req_fire;
    logic              disp_fire;
    logic              sad_fire;
    logic              all_returned;

    assign req_fire     = req_valid && req_ready;
    assign disp_fire    = disp_valid && disp_ready;
    assign all_returned = (ret_cnt == n_disp);
    assign sad_fire     = sad_valid && ((state == ISSUE) || (state == DRAIN))
                          && (ret_cnt < issue_cnt);
    assign disp_idx     = disp_valid ? issue_cnt : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        disp_valid = 1'b0;
        res_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                disp_valid = 1'b1;
                if (disp_ready && (issue_cnt == n_disp - 1'b1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (all_returned)
                    state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Search length and issue/return counters; both may step in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_disp    <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (req_fire) begin
            n_disp    <= clamp_ndisp(req_ndisp);
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (disp_fire && (issue_cnt != DISP_W'(MAX_DISP)))
                issue_cnt <= issue_cnt + 1'b1;
            if (sad_fire && (ret_cnt != DISP_W'(MAX_DISP)))
                ret_cnt <= ret_cnt + 1'b1;
        end
    end

    // Returns arrive in issue order, so the return count is the disparity.
    sad_wta_min u_wta (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (req_fire),
        .valid     (sad_fire),
        .cost      (sad_in),
        .index     (ret_cnt),
        .best_sad  (best_sad),
        .best_disp (best_disp)
    );

    // Capture the winner on DRAIN exit and hold it through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_disp <= '0;
            res_sad  <= '0;
        end else if ((state == DRAIN) && all_returned) begin
            res_disp <= best_disp;
            res_sad  <= best_sad;
        end
    end

`ifdef SAD_REJECT_EN
    // Rejection flag captured alongside the winning cost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_reject <= 1'b0;
        else if ((state == DRAIN) && all_returned)
            res_reject <= (best_sad > REJECT_THRESH);
    end
`else
    assign res_reject = 1'b0;
`endif

endmodule
